// File: rtl/adder_lcd_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_lcd_writer_pkg
// Description : Shared constants, default delay values, FSM state encoding
//               and the hex-to-ASCII helper for the adder result LCD writer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package adder_lcd_writer_pkg;

  // LCD command bytes
  localparam logic [7:0] FUNC_SET   = 8'h28;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1_ADDR = 8'h80;

  // ASCII characters used on line 1
  localparam logic [7:0] CH_S     = 8'h53;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_V     = 8'h56;
  localparam logic [7:0] CH_DASH  = 8'h2D;

  // Default delays in 50 MHz clock cycles
  localparam int T_POWERON_DEF    = 750000;
  localparam int T_INIT_LONG_DEF  = 205000;
  localparam int T_INIT_SHORT_DEF = 5000;
  localparam int T_CMD_DEF        = 2000;
  localparam int T_CLEAR_DEF      = 82000;
  localparam int T_GAP_DEF        = 50;

  typedef enum logic [2:0] {
    POWERON_WAIT = 3'd0,
    INIT_NIB     = 3'd1,
    CFG          = 3'd2,
    REFRESH      = 3'd3,
    IDLE         = 3'd4
  } state_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage : adder_lcd_writer_pkg
`default_nettype wire

// File: rtl/adder_lcd_writer_strobe.sv
`default_nettype none
// ============================================================================
// Module      : lcd_nibble_strobe
// Description : Drives one 16-cycle LCD nibble write. Data and RS are latched
//               at c0 and held through c15; enable is high for c2..c13.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               start        - request a strobe (ignored while active)
//               nibble, rs   - data nibble and register select to write
//               lcd_e/lcd_d/lcd_rs - registered LCD bus outputs
//               done         - high during c15, the last strobe cycle
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_nibble_strobe (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       done
);

  logic       active;
  logic [3:0] cnt;    // equals k during cycle ck of the strobe

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= 4'd0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'd0;
      lcd_rs <= 1'b0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= 4'd0;
      lcd_d  <= nibble;
      lcd_rs <= rs;
    end else if (active) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd1)  lcd_e  <= 1'b1;
      if (cnt == 4'd13) lcd_e  <= 1'b0;
      if (cnt == 4'd15) active <= 1'b0;
    end
  end

  assign done = active && (cnt == 4'd15);

endmodule : lcd_nibble_strobe
`default_nettype wire

// File: rtl/adder_lcd_writer.sv
`default_nettype none
// ============================================================================
// Module      : adder_lcd_writer
// Description : Runs the 16x2 LCD 4-bit power-on initialisation, then writes
//               "S=hh V" (or "S=hh -") on line 1 for each captured adder
//               result. Updates arriving while busy are coalesced into one
//               pending refresh (last value wins).
// Ports       : clk, reset      - 50 MHz clock, synchronous active-high reset
//               sum, overflow   - adder result and overflow flag
//               update          - one-cycle capture/refresh request
//               lcd_e, lcd_rs, lcd_rw, lcd_d - LCD write-only bus
//               busy            - high until idle with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module adder_lcd_writer
  import adder_lcd_writer_pkg::*;
#(
  parameter int T_POWERON    = T_POWERON_DEF,
  parameter int T_INIT_LONG  = T_INIT_LONG_DEF,
  parameter int T_INIT_SHORT = T_INIT_SHORT_DEF,
  parameter int T_CMD        = T_CMD_DEF,
  parameter int T_CLEAR      = T_CLEAR_DEF,
  parameter int T_GAP        = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] sum,
  input  logic       overflow,
  input  logic       update,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d,
  output logic       busy
);

  localparam int T_MAX = (T_POWERON > T_INIT_LONG) ? T_POWERON : T_INIT_LONG;
  localparam int DW    = $clog2(T_MAX + 1);

  // Counters are loaded with T-1 so that the next start is issued in the
  // last idle cycle and the strobe's c0 lands exactly T cycles later.
  localparam logic [DW-1:0] D_POWERON    = DW'(T_POWERON - 1);
  localparam logic [DW-1:0] D_INIT_LONG  = DW'(T_INIT_LONG - 1);
  localparam logic [DW-1:0] D_INIT_SHORT = DW'(T_INIT_SHORT - 1);
  localparam logic [DW-1:0] D_CMD        = DW'(T_CMD - 1);
  localparam logic [DW-1:0] D_CLEAR      = DW'(T_CLEAR - 1);
  localparam logic [DW-1:0] D_GAP        = DW'(T_GAP - 1);
  localparam logic [2:0]    IDX_DONE     = 3'd7;

  state_t        state;
  logic          waiting;     // 1: counting delay, 0: strobe in flight
  logic [2:0]    idx;         // item index within the current state
  logic          lo;          // lower nibble of a byte is next/in flight
  logic [DW-1:0] delay;
  logic [6:0]    disp_sum, pend_sum;
  logic          disp_ovf, pend_ovf, pending;

  logic [7:0]    item_byte;
  logic          item_rs, item_single;
  logic [DW-1:0] item_wait;
  logic [2:0]    last_idx;
  logic [3:0]    nibble;
  logic          start, strobe_done;

  // Describes the item at idx; POWERON_WAIT presents the first init nibble.
  always_comb begin
    item_byte   = 8'h00;
    item_rs     = 1'b0;
    item_single = 1'b0;
    item_wait   = D_CMD;
    last_idx    = 3'd0;
    unique case (state)
      POWERON_WAIT, INIT_NIB: begin
        item_single = 1'b1;
        item_byte   = (idx == 3'd3) ? 8'h02 : 8'h03;
        item_wait   = (idx == 3'd0) ? D_INIT_LONG :
                      (idx == 3'd1) ? D_INIT_SHORT : D_CMD;
        last_idx    = 3'd3;
      end
      CFG: begin
        last_idx = 3'd3;
        unique case (idx)
          3'd0:    item_byte = FUNC_SET;
          3'd1:    item_byte = ENTRY_MODE;
          3'd2:    item_byte = DISP_ON;
          default: begin
            item_byte = CLEAR;
            item_wait = D_CLEAR;
          end
        endcase
      end
      REFRESH: begin
        last_idx = 3'd6;
        item_rs  = (idx != 3'd0);
        unique case (idx)
          3'd0:    item_byte = LINE1_ADDR;
          3'd1:    item_byte = CH_S;
          3'd2:    item_byte = CH_EQ;
          3'd3:    item_byte = hex_char({1'b0, disp_sum[6:4]});
          3'd4:    item_byte = hex_char(disp_sum[3:0]);
          3'd5:    item_byte = CH_SPACE;
          default: item_byte = disp_ovf ? CH_V : CH_DASH;
        endcase
      end
      default: ;
    endcase
    nibble = (item_single || lo) ? item_byte[3:0] : item_byte[7:4];
    start  = (state != IDLE) && waiting && (delay == '0) && (idx <= last_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= POWERON_WAIT;
      waiting  <= 1'b1;
      idx      <= 3'd0;
      lo       <= 1'b0;
      delay    <= D_POWERON;
      disp_sum <= 7'd0;
      disp_ovf <= 1'b0;
      pend_sum <= 7'd0;
      pend_ovf <= 1'b0;
      pending  <= 1'b0;
      busy     <= 1'b1;
    end else begin
      if (update && state != IDLE) begin
        pend_sum <= sum;
        pend_ovf <= overflow;
        pending  <= 1'b1;
      end
      if (state == IDLE) begin
        if (update || pending) begin
          disp_sum <= update ? sum : pend_sum;
          disp_ovf <= update ? overflow : pend_ovf;
          pending  <= 1'b0;
          state    <= REFRESH;
          idx      <= 3'd0;
          lo       <= 1'b0;
          waiting  <= 1'b1;
          delay    <= '0;
          busy     <= 1'b1;
        end
      end else if (waiting) begin
        if (delay != '0) begin
          delay <= delay - DW'(1);
        end else if (start) begin
          waiting <= 1'b0;
          if (state == POWERON_WAIT) state <= INIT_NIB;
        end else if (pending) begin
          // Refresh finished with a newer value waiting: go again.
          // A same-cycle update stays pending behind it.
          disp_sum <= pend_sum;
          disp_ovf <= pend_ovf;
          pending  <= update;
          idx      <= 3'd0;
        end else begin
          state <= IDLE;
          busy  <= update;
        end
      end else if (strobe_done) begin
        waiting <= 1'b1;
        if (!item_single && !lo) begin
          lo    <= 1'b1;
          delay <= D_GAP;
        end else begin
          lo    <= 1'b0;
          delay <= item_wait;
          if (idx != last_idx) begin
            idx <= idx + 3'd1;
          end else if (state == INIT_NIB) begin
            state <= CFG;
            idx   <= 3'd0;
          end else if (state == CFG) begin
            state    <= REFRESH;
            idx      <= 3'd0;
            disp_sum <= pending ? pend_sum : sum;
            disp_ovf <= pending ? pend_ovf : overflow;
            if (pending) pending <= update;
          end else begin
            idx <= IDX_DONE;
          end
        end
      end
    end
  end

  lcd_nibble_strobe u_strobe (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .nibble (nibble),
    .rs     (item_rs),
    .lcd_e  (lcd_e),
    .lcd_d  (lcd_d),
    .lcd_rs (lcd_rs),
    .done   (strobe_done)
  );

  assign lcd_rw = 1'b0;

endmodule : adder_lcd_writer
`default_nettype wire
